// File: rtl/func_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : func_pkg
//  Purpose  : Shared widths, coefficient-set type, reset coefficients and the
//             saturating narrow helper for the cubic curve evaluator.
//  Revision : 1.0 - initial release
// ============================================================================
package func_pkg;

   localparam int COEFW = 16;   // coefficient width, signed Q8.8
   localparam int FRACW = 8;    // fractional bits in coefficients and results
   localparam int SATW  = 32;   // width every Horner intermediate is pinned to
   localparam int WIDEW = 64;   // carrier width for full-precision values

   typedef struct packed {
      logic signed [COEFW-1:0] a;
      logic signed [COEFW-1:0] b;
      logic signed [COEFW-1:0] c;
      logic signed [COEFW-1:0] d;
   } coef_t;

   // Power-up curve is y = x: only the linear term is 1.0.
   localparam coef_t c_coef_rst = '{
      a: '0,
      b: '0,
      c: COEFW'(1 << FRACW),
      d: '0
   };

   // Clamp a full-precision signed value into SATW bits instead of wrapping.
   // In range exactly when every bit from the SATW-1 position upward agrees.
   function automatic logic signed [SATW-1:0] sat(input logic signed [WIDEW-1:0] v);
      logic [WIDEW-SATW:0] top;
      top = v[WIDEW-1:SATW-1];
      if ((&top) || !(|top))
         sat = v[SATW-1:0];
      else if (v[WIDEW-1])
         sat = {1'b1, {(SATW-1){1'b0}}};
      else
         sat = {1'b0, {(SATW-1){1'b1}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/horner_stage.sv
`default_nettype none
// ============================================================================
//  Module   : horner_stage
//  Purpose  : One registered Horner step, h_out = sat(h_in * x + k), carrying
//             x, y and the coefficient snapshot alongside the result so later
//             stages see the same sample and the same coefficient set.
//  Revision : 1.0 - initial release
// ============================================================================
module horner_stage
   import func_pkg::*;
#(
   parameter int HW    = COEFW,
   parameter int CORDW = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [HW-1:0]    h_in,
   input  logic signed [COEFW-1:0] k,
   input  logic signed [CORDW-1:0] x_in,
   input  logic signed [CORDW-1:0] y_in,
   input  coef_t                   coef_in,
   output logic signed [SATW-1:0]  h_out,
   output logic signed [CORDW-1:0] x_out,
   output logic signed [CORDW-1:0] y_out,
   output coef_t                   coef_out
);

   localparam int c_pw = HW + CORDW;   // exact product width
   localparam int c_sw = c_pw + 1;     // exact sum width

   logic signed [c_pw-1:0] w_prod;
   logic signed [c_sw-1:0] w_sum;

   // Both operands sign-extended to the product width so the low c_pw bits
   // of the multiply are the exact signed product.
   assign w_prod = $signed({{CORDW{h_in[HW-1]}}, h_in}) *
                   $signed({{HW{x_in[CORDW-1]}}, x_in});
   assign w_sum  = {w_prod[c_pw-1], w_prod} + {{(c_sw-COEFW){k[COEFW-1]}}, k};

   // Register the saturated step result together with its sample context.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_out    <= '0;
         x_out    <= '0;
         y_out    <= '0;
         coef_out <= '0;
      end else begin
         h_out    <= sat({{(WIDEW-c_sw){w_sum[c_sw-1]}}, w_sum});
         x_out    <= x_in;
         y_out    <= y_in;
         coef_out <= coef_in;
      end
   end

endmodule
`default_nettype wire

// File: rtl/func_cubic.sv
`default_nettype none
// ============================================================================
//  Module   : func_cubic
//  Purpose  : Three-stage Horner evaluator of f(x) = a*x^3 + b*x^2 + c*x + d
//             that flags screen points within THICK pixels of the curve.
//             Coefficients are double-buffered and swap only on frame.
//             r reflects the sample presented three clock edges earlier.
//  Revision : 1.0 - initial release
// ============================================================================
module func_cubic
   import func_pkg::*;
#(
   parameter int CORDW = 12,
   parameter int THICK = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [CORDW-1:0] x,
   input  logic signed [CORDW-1:0] y,
   input  logic signed [COEFW-1:0] coef_a,
   input  logic signed [COEFW-1:0] coef_b,
   input  logic signed [COEFW-1:0] coef_c,
   input  logic signed [COEFW-1:0] coef_d,
   input  logic                    coef_load,
   input  logic                    frame,
   output logic                    coef_pending,
   output logic                    r
);

   localparam int                   c_pw3       = SATW + CORDW;
   localparam int                   c_sw3       = c_pw3 + 1;
   localparam logic signed [SATW:0] c_thick     = (SATW+1)'(THICK);
   localparam logic signed [SATW:0] c_thick_neg = -c_thick;

   coef_t                   r_active;
   coef_t                   r_shadow;
   logic                    r_pending;
   logic [2:0]              r_valid;

   coef_t                   w_coef_in;
   coef_t                   w_coef2;
   coef_t                   w_coef3;
   logic signed [SATW-1:0]  w_h1;
   logic signed [SATW-1:0]  w_h2;
   logic signed [CORDW-1:0] w_x2;
   logic signed [CORDW-1:0] w_y2;
   logic signed [CORDW-1:0] w_x3;
   logic signed [CORDW-1:0] w_y3;
   logic signed [c_pw3-1:0] w_prod3;
   logic signed [c_sw3-1:0] w_sum3;
   logic signed [SATW-1:0]  w_f;
   logic signed [SATW-1:0]  w_fi;
   logic signed [SATW:0]    w_diff;
   logic                    w_on;
   logic                    w_unused;

   assign w_coef_in    = '{a: coef_a, b: coef_b, c: coef_c, d: coef_d};
   assign coef_pending = r_pending;

   // Shadow/active coefficient banks: a frame commits whatever was pending
   // before this edge, while a simultaneous load refills the shadow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active  <= c_coef_rst;
         r_shadow  <= c_coef_rst;
         r_pending <= 1'b0;
      end else begin
         if (frame && r_pending)
            r_active <= r_shadow;
         if (coef_load)
            r_shadow <= w_coef_in;
         r_pending <= coef_load || (r_pending && !frame);
      end
   end

   horner_stage #(
      .HW    (COEFW),
      .CORDW (CORDW)
   ) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .h_in     (r_active.a),
      .k        (r_active.b),
      .x_in     (x),
      .y_in     (y),
      .coef_in  (r_active),
      .h_out    (w_h1),
      .x_out    (w_x2),
      .y_out    (w_y2),
      .coef_out (w_coef2)
   );

   horner_stage #(
      .HW    (SATW),
      .CORDW (CORDW)
   ) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .h_in     (w_h1),
      .k        (w_coef2.c),
      .x_in     (w_x2),
      .y_in     (w_y2),
      .coef_in  (w_coef2),
      .h_out    (w_h2),
      .x_out    (w_x3),
      .y_out    (w_y3),
      .coef_out (w_coef3)
   );

   // Final Horner step uses the d captured with this sample, then drops the
   // fraction with an arithmetic shift so negative values floor.
   assign w_prod3 = $signed({{CORDW{w_h2[SATW-1]}}, w_h2}) *
                    $signed({{SATW{w_x3[CORDW-1]}}, w_x3});
   assign w_sum3  = {w_prod3[c_pw3-1], w_prod3} +
                    {{(c_sw3-COEFW){w_coef3.d[COEFW-1]}}, w_coef3.d};
   assign w_f     = sat({{(WIDEW-c_sw3){w_sum3[c_sw3-1]}}, w_sum3});
   assign w_fi    = w_f >>> FRACW;
   assign w_diff  = {w_fi[SATW-1], w_fi} - {{(SATW+1-CORDW){w_y3[CORDW-1]}}, w_y3};
   assign w_on    = (w_diff <= c_thick) && (w_diff >= c_thick_neg);

   // Only d and the last valid bit are consumed past stage two.
   assign w_unused = ^{w_coef3.a, w_coef3.b, w_coef3.c, r_valid[2]};

   // Valid tracking and the draw flag: r stays low until a real sample has
   // crossed both Horner stages after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 3'b000;
         r       <= 1'b0;
      end else begin
         r_valid <= {r_valid[1:0], 1'b1};
         r       <= r_valid[1] && w_on;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_func_cubic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_func_cubic
//  Purpose  : Directed bench for func_cubic; two instances (THICK=1, THICK=0)
//             share stimulus and are checked against hand-computed tables.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_func_cubic;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [11:0] x, y;
   logic signed [15:0] coef_a, coef_b, coef_c, coef_d;
   logic               coef_load, frame;
   logic               pend1, pend0, r1, r0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic signed [11:0] x;
      logic signed [11:0] y;
      logic               e1;   // expected r with THICK=1
      logic               e0;   // expected r with THICK=0
   } vec_t;

   vec_t tbl[64];
   int   n_tbl = 0;

   always #5 clk = ~clk;

   func_cubic #(.CORDW(12), .THICK(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y),
      .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
      .coef_load(coef_load), .frame(frame),
      .coef_pending(pend1), .r(r1)
   );

   func_cubic #(.CORDW(12), .THICK(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y),
      .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
      .coef_load(coef_load), .frame(frame),
      .coef_pending(pend0), .r(r0)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input int vx, input int vy, input logic e1, input logic e0);
      tbl[n_tbl].x  = 12'(vx);
      tbl[n_tbl].y  = 12'(vy);
      tbl[n_tbl].e1 = e1;
      tbl[n_tbl].e0 = e0;
      n_tbl++;
   endtask

   // Stream table rows lo..hi back to back, one per clock; each row's r is
   // checked three edges after it was presented. frame_at pulses frame
   // together with that row.
   task automatic run(input int lo, input int hi, input bit zchk, input int frame_at);
      for (int k = lo; k <= hi + 2; k++) begin
         if (k <= hi) begin
            x     = tbl[k].x;
            y     = tbl[k].y;
            frame = (k == frame_at);
         end else begin
            frame = 1'b0;
         end
         @(negedge clk);
         if (k - 2 >= lo) begin
            chk($sformatf("row%0d_r1 x=%0d y=%0d", k-2, tbl[k-2].x, tbl[k-2].y), r1, tbl[k-2].e1);
            chk($sformatf("row%0d_r0 x=%0d y=%0d", k-2, tbl[k-2].x, tbl[k-2].y), r0, tbl[k-2].e0);
         end else if (zchk) begin
            chk($sformatf("startup_r1_cyc%0d", k), r1, 1'b0);
            chk($sformatf("startup_r0_cyc%0d", k), r0, 1'b0);
         end
      end
      frame = 1'b0;
   endtask

   task automatic load(input int a, input int b, input int c, input int d, input bit commit);
      coef_a    = 16'(a);
      coef_b    = 16'(b);
      coef_c    = 16'(c);
      coef_d    = 16'(d);
      coef_load = 1'b1;
      @(negedge clk);
      coef_load = 1'b0;
      chk("load_pending1", pend1, 1'b1);
      chk("load_pending0", pend0, 1'b1);
      if (commit) begin
         frame = 1'b1;
         @(negedge clk);
         frame = 1'b0;
         chk("commit_pending1", pend1, 1'b0);
         chk("commit_pending0", pend0, 1'b0);
      end
   endtask

   int p0, p1, p2, p3, p4, p5, p6, p7, p8, pe;

   initial begin
      rst_n = 1'b0; x = '0; y = '0;
      coef_a = '0; coef_b = '0; coef_c = '0; coef_d = '0;
      coef_load = 1'b0; frame = 1'b0;

      // y = x (reset set)
      p0 = n_tbl;
      add(5, 5, 1, 1);  add(5, 6, 1, 0);  add(5, 7, 0, 0);
      add(-20, -21, 1, 0); add(0, 0, 1, 1);
      add(2047, 2047, 1, 1); add(-2048, -2047, 1, 0);
      // shadow holds x^2 but is not committed yet
      p1 = n_tbl;
      add(10, 100, 0, 0); add(10, 10, 1, 1);
      // y = x^2
      p2 = n_tbl;
      add(10, 100, 1, 1); add(10, 102, 0, 0); add(10, 101, 1, 0);
      add(-10, 100, 1, 1); add(3, 9, 1, 1);
      // a = 0x7FFF saturation
      p3 = n_tbl;
      add(2047, 2047, 0, 0); add(-2048, -2048, 0, 0); add(0, 0, 1, 1);
      add(1, 127, 1, 1); add(1, 128, 1, 0);
      // y = 0.5x, floor toward -inf
      p4 = n_tbl;
      add(-3, -2, 1, 1); add(-3, -1, 1, 0); add(3, 1, 1, 1);
      add(3, 2, 1, 0); add(-1, -1, 1, 1); add(1, 0, 1, 1);
      // y = x^3 - 2x + 3
      p5 = n_tbl;
      add(2, 7, 1, 1); add(-3, -18, 1, 1); add(12, 1707, 1, 1);
      add(0, 3, 1, 1); add(0, 4, 1, 0); add(0, 5, 0, 0); add(1, 2, 1, 1);
      // mid-stream commit from the cubic to y = x on the third row
      p6 = n_tbl;
      add(2, 7, 1, 1); add(3, 24, 1, 1); add(-3, -18, 1, 1);
      add(4, 4, 1, 1); add(5, 5, 1, 1); add(-6, -6, 1, 1);
      // after simultaneous load+frame: x^2 active
      p7 = n_tbl;
      add(10, 100, 1, 1); add(10, 20, 0, 0); add(-5, 25, 1, 1);
      // then y = 2x
      p8 = n_tbl;
      add(10, 20, 1, 1); add(10, 100, 0, 0); add(-7, -14, 1, 1); add(-7, -13, 1, 0);
      pe = n_tbl;

      repeat (3) @(negedge clk);
      chk("reset_r1", r1, 1'b0);
      chk("reset_r0", r0, 1'b0);
      chk("reset_pending", pend1, 1'b0);

      rst_n = 1'b1;
      run(p0, p1 - 1, 1'b1, -1);

      load(0, 256, 0, 0, 1'b0);
      run(p1, p2 - 1, 1'b0, -1);
      chk("deferred_pending", pend1, 1'b1);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      chk("deferred_commit_pending", pend1, 1'b0);
      run(p2, p3 - 1, 1'b0, -1);

      load(32'h7FFF, 0, 0, 0, 1'b1);
      run(p3, p4 - 1, 1'b0, -1);

      load(0, 0, 128, 0, 1'b1);
      run(p4, p5 - 1, 1'b0, -1);

      load(256, 0, -512, 768, 1'b1);
      run(p5, p6 - 1, 1'b0, -1);

      load(0, 0, 256, 0, 1'b0);
      run(p6, p7 - 1, 1'b0, p6 + 2);
      chk("midstream_commit_pending", pend1, 1'b0);

      // Simultaneous load and frame: pending x^2 commits, 2x becomes pending.
      load(0, 256, 0, 0, 1'b0);
      coef_a = 16'sd0; coef_b = 16'sd0; coef_c = 16'sd512; coef_d = 16'sd0;
      coef_load = 1'b1;
      frame     = 1'b1;
      @(negedge clk);
      coef_load = 1'b0;
      frame     = 1'b0;
      chk("simul_pending1", pend1, 1'b1);
      chk("simul_pending0", pend0, 1'b1);
      run(p7, p8 - 1, 1'b0, -1);
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      chk("simul_second_commit_pending", pend1, 1'b0);
      run(p8, pe - 1, 1'b0, -1);

      // Mid-stream reset with x^2 active and a full pipeline of hits.
      load(0, 256, 0, 0, 1'b1);
      x = 12'sd10; y = 12'sd100;
      repeat (3) @(negedge clk);
      chk("prereset_r1", r1, 1'b1);
      chk("prereset_r0", r0, 1'b1);
      load(0, 0, 512, 0, 1'b0);
      rst_n = 1'b0;
      y     = 12'sd10;
      @(negedge clk);
      chk("inreset_r1", r1, 1'b0);
      chk("inreset_r0", r0, 1'b0);
      chk("inreset_pending", pend1, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("postreset_r1_cyc%0d", i), r1, 1'b0);
         chk($sformatf("postreset_r0_cyc%0d", i), r0, 1'b0);
      end
      @(negedge clk);
      chk("postreset_yx_r1", r1, 1'b1);
      chk("postreset_yx_r0", r0, 1'b1);
      y = 12'sd100;
      repeat (3) @(negedge clk);
      chk("postreset_not_sq_r1", r1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
